voice_allocator: RTL and testbench

- Polyphony controller in front of NCH synth channel instances.
- Accepts note-on/note-off requests over a valid/ready handshake and assigns each note to a channel.
- Drives each channel's enable, pitch divider value and waveform select. Steals the oldest voice when all channels are busy.
- Sits between the note source (keyboard/MIDI decoder) and the channel array.

---
 rtl/voice_allocator.sv | 214 +++++++++++++++++++++
 tb/tb_voice_allocator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator. It assigns note-on/note-off requests to NCH
// synth channels and steals the oldest voice when every channel is busy.
module voice_allocator #(
    parameter int NCH = 4,
    parameter int C   = 14,
    parameter int K   = 7,
    parameter int AW  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_on,
    input  logic [K-1:0]          req_key,
    input  logic [C-1:0]          req_pitch,
    input  logic [1:0]            req_wave,
    output logic [NCH-1:0]        ch_ena,
    output logic [NCH*C-1:0]      ch_pitch,
    output logic [NCH*2-1:0]      ch_wave,
    output logic                  steal,
    output logic [$clog2(NCH):0]  active_cnt
);

    localparam int IW = $clog2(NCH);
    localparam int CW = $clog2(NCH) + 1;
    localparam logic [AW-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT} state_t;

    state_t          state_q, state_d;
    logic            started_q;
    logic            accept;

    logic            lat_on_q;
    logic [K-1:0]    lat_key_q;
    logic [C-1:0]    lat_pitch_q;
    logic [1:0]      lat_wave_q;

    logic [NCH-1:0]  ena_q, ena_d;
    logic [K-1:0]    key_q   [NCH];
    logic [K-1:0]    key_d   [NCH];
    logic [C-1:0]    pitch_q [NCH];
    logic [C-1:0]    pitch_d [NCH];
    logic [1:0]      wave_q  [NCH];
    logic [1:0]      wave_d  [NCH];
    logic [AW-1:0]   age_q   [NCH];
    logic [AW-1:0]   age_d   [NCH];

    logic            match_hit, free_hit, old_hit;
    logic [IW-1:0]   match_idx, free_idx, old_idx;
    logic [AW-1:0]   old_age;
    logic            match_hit_q, free_hit_q;
    logic [IW-1:0]   match_idx_q, free_idx_q, old_idx_q;
    logic [IW-1:0]   tgt_idx;

    logic            steal_q, steal_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Ready is held low until the first edge after reset release.
    assign req_ready = started_q && (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // FSM state register plus the post-reset ready gate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
        end
    end

    // FSM next state: one request takes IDLE -> LOOKUP -> COMMIT
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = LOOKUP;
            LOOKUP:  state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the request on acceptance; wave code 2 is folded to square
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_on_q    <= 1'b0;
            lat_key_q   <= '0;
            lat_pitch_q <= '0;
            lat_wave_q  <= '0;
        end else if (accept) begin
            lat_on_q    <= req_on;
            lat_key_q   <= req_key;
            lat_pitch_q <= req_pitch;
            lat_wave_q  <= (req_wave == 2'd2) ? 2'd0 : req_wave;
        end
    end

    // Search for matching key, lowest free channel and oldest active channel
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        old_hit   = 1'b0;
        old_idx   = '0;
        old_age   = '0;
        // Descending scan so the lowest index wins last.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ena_q[i] && (key_q[i] == lat_key_q)) begin
                match_hit = 1'b1;
                match_idx = IW'(i);
            end
            if (!ena_q[i]) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
        end
        // Ascending scan with strict compare keeps ties on the lowest index.
        for (int i = 0; i < NCH; i++) begin
            if (ena_q[i] && (!old_hit || (age_q[i] > old_age))) begin
                old_hit = 1'b1;
                old_idx = IW'(i);
                old_age = age_q[i];
            end
        end
    end

    // Register the lookup results during LOOKUP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_hit_q <= 1'b0;
            match_idx_q <= '0;
            free_hit_q  <= 1'b0;
            free_idx_q  <= '0;
            old_idx_q   <= '0;
        end else if (state_q == LOOKUP) begin
            match_hit_q <= match_hit;
            match_idx_q <= match_idx;
            free_hit_q  <= free_hit;
            free_idx_q  <= free_idx;
            old_idx_q   <= old_idx;
        end
    end

    // Channel table update applied in COMMIT
    always_comb begin
        ena_d   = ena_q;
        key_d   = key_q;
        pitch_d = pitch_q;
        wave_d  = wave_q;
        age_d   = age_q;
        steal_d = 1'b0;
        tgt_idx = match_hit_q ? match_idx_q : (free_hit_q ? free_idx_q : old_idx_q);
        if (state_q == COMMIT) begin
            if (lat_on_q) begin
                for (int i = 0; i < NCH; i++) begin
                    if (ena_q[i] && (age_q[i] != AGE_MAX)) begin
                        age_d[i] = age_q[i] + AW'(1);
                    end
                end
                ena_d[tgt_idx]   = 1'b1;
                key_d[tgt_idx]   = lat_key_q;
                pitch_d[tgt_idx] = lat_pitch_q;
                wave_d[tgt_idx]  = lat_wave_q;
                age_d[tgt_idx]   = '0;
                steal_d          = !match_hit_q && !free_hit_q;
            end else if (match_hit_q) begin
                ena_d[match_idx_q] = 1'b0;
                age_d[match_idx_q] = '0;
            end
        end
        cnt_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d = cnt_d + CW'(ena_d[i]);
        end
    end

    // Channel table, steal pulse and active count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_q   <= '0;
            steal_q <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                key_q[i]   <= '0;
                pitch_q[i] <= '0;
                wave_q[i]  <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            ena_q   <= ena_d;
            key_q   <= key_d;
            pitch_q <= pitch_d;
            wave_q  <= wave_d;
            age_q   <= age_d;
            steal_q <= steal_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ch_ena     = ena_q;
    assign steal      = steal_q;
    assign active_cnt = cnt_q;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_pack
            assign ch_pitch[gi*C +: C] = pitch_q[gi];
            assign ch_wave[gi*2 +: 2]  = wave_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator: directed scenarios plus random traffic,
// checked against a transaction-level channel model.
module tb_voice_allocator;

    localparam int NCH = 4;
    localparam int C   = 14;
    localparam int K   = 7;
    localparam int AW  = 4;
    localparam int AGE_MAX = (1 << AW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic                 req_on = 1'b0;
    logic [K-1:0]         req_key = '0;
    logic [C-1:0]         req_pitch = '0;
    logic [1:0]           req_wave = '0;
    logic [NCH-1:0]       ch_ena;
    logic [NCH*C-1:0]     ch_pitch;
    logic [NCH*2-1:0]     ch_wave;
    logic                 steal;
    logic [$clog2(NCH):0] active_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Behavioural model of the channel table
    bit m_ena   [NCH];
    int m_key   [NCH];
    int m_pitch [NCH];
    int m_wave  [NCH];
    int m_age   [NCH];

    voice_allocator #(.NCH(NCH), .C(C), .K(K), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_on     (req_on),
        .req_key    (req_key),
        .req_pitch  (req_pitch),
        .req_wave   (req_wave),
        .ch_ena     (ch_ena),
        .ch_pitch   (ch_pitch),
        .ch_wave    (ch_wave),
        .steal      (steal),
        .active_cnt (active_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_ena[i] = 0; m_key[i] = 0; m_pitch[i] = 0; m_wave[i] = 0; m_age[i] = 0;
        end
    endtask

    // Apply one request at transaction level; returns whether a voice is stolen
    task automatic model_apply(input bit on, input int key, input int pitch,
                               input int wave, output bit st);
        int m = -1;
        int f = -1;
        int o = -1;
        int t;
        st = 0;
        for (int i = 0; i < NCH; i++) begin
            if (m < 0 && m_ena[i] && m_key[i] == key) m = i;
            if (f < 0 && !m_ena[i]) f = i;
            if (m_ena[i] && (o < 0 || m_age[i] > m_age[o])) o = i;
        end
        if (on) begin
            t  = (m >= 0) ? m : ((f >= 0) ? f : o);
            st = (m < 0) && (f < 0);
            for (int i = 0; i < NCH; i++) begin
                if (m_ena[i] && i != t) m_age[i] = (m_age[i] >= AGE_MAX) ? AGE_MAX : m_age[i] + 1;
            end
            m_ena[t] = 1; m_key[t] = key; m_pitch[t] = pitch;
            m_wave[t] = (wave == 2) ? 0 : wave;
            m_age[t] = 0;
        end else if (m >= 0) begin
            m_ena[m] = 0;
            m_age[m] = 0;
        end
    endtask

    task automatic compare_all(input bit exp_st);
        logic [63:0] ee = '0;
        logic [63:0] ep = '0;
        logic [63:0] ew = '0;
        int cnt = 0;
        for (int i = 0; i < NCH; i++) begin
            ee[i] = m_ena[i];
            ep = ep | (64'(m_pitch[i]) << (i * C));
            ew = ew | (64'(m_wave[i]) << (i * 2));
            cnt += int'(m_ena[i]);
        end
        chk("ch_ena",     64'(ch_ena),     ee);
        chk("ch_pitch",   64'(ch_pitch),   ep);
        chk("ch_wave",    64'(ch_wave),    ew);
        chk("active_cnt", 64'(active_cnt), 64'(cnt));
        chk("steal",      64'(steal),      64'(exp_st));
        chk("ready_idle", 64'(req_ready),  64'd1);
    endtask

    // Called at a negedge; returns at the negedge after the commit edge
    task automatic do_req(input bit on, input int key, input int pitch, input int wave);
        int n = 0;
        bit st;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1; req_on = on; req_key = K'(key); req_pitch = C'(pitch); req_wave = 2'(wave);
        @(posedge clk);
        @(negedge clk);
        chk("ready_lookup", 64'(req_ready), 64'd0);
        chk("steal_cleared", 64'(steal), 64'd0);
        // Garbage on the bus while busy must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_on = 1'($urandom); req_key = K'($urandom); req_pitch = C'($urandom); req_wave = 2'($urandom);
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        model_apply(on, key, pitch, wave, st);
        $display("req on=%0d key=%0d pitch=%0d wave=%0d -> ena=%b steal=%0d cnt=%0d",
                 on, key, pitch, wave, ch_ena, steal, active_cnt);
        compare_all(st);
    endtask

    task automatic apply_reset();
        req_valid = 0;
        rst_n = 0;
        #1;
        chk("rst_ena",   64'(ch_ena),     64'd0);
        chk("rst_pitch", 64'(ch_pitch),   64'd0);
        chk("rst_wave",  64'(ch_wave),    64'd0);
        chk("rst_steal", 64'(steal),      64'd0);
        chk("rst_cnt",   64'(active_cnt), 64'd0);
        chk("rst_ready", 64'(req_ready),  64'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("ready_after_release", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("ready_first_edge", 64'(req_ready), 64'd1);
        @(negedge clk);
    endtask

    task automatic burst9();
        int rdy = 0;
        int q_key[$];
        int q_pitch[$];
        int q_wave[$];
        bit st = 0;
        for (int c = 0; c < 9; c++) begin
            req_valid = 1; req_on = 1; req_key = K'(110 + c);
            req_pitch = C'(1000 + c); req_wave = 2'(c % 4);
            if (req_ready) begin
                rdy++;
                q_key.push_back(110 + c); q_pitch.push_back(1000 + c); q_wave.push_back(c % 4);
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 0;
        chk("burst_ready_cycles", 64'(rdy), 64'd3);
        for (int j = 0; j < q_key.size(); j++) model_apply(1, q_key[j], q_pitch[j], q_wave[j], st);
        $display("burst accepted=%0d -> ena=%b steal=%0d cnt=%0d", rdy, ch_ena, steal, active_cnt);
        compare_all(st);
    endtask

    initial begin
        model_clear();
        #2;
        apply_reset();

        // Single note-on into an empty table
        do_req(1, 69, 212, 0);
        chk("t1_pitch0", 64'(ch_pitch[C-1:0]), 64'd212);

        // Fill all channels, then steal the oldest
        apply_reset();
        do_req(1, 60, 300, 1);
        do_req(1, 62, 310, 3);
        do_req(1, 64, 320, 0);
        do_req(1, 65, 330, 1);
        do_req(1, 67, 340, 3);
        chk("t2_ch0_pitch", 64'(ch_pitch[C-1:0]), 64'd340);

        // Retrigger of a sounding key
        do_req(1, 62, 105, 1);
        chk("t3_ch1_wave", 64'(ch_wave[3:2]), 64'd1);

        // Note-offs, then reuse of the freed channel with wave code 2
        do_req(0, 64, 0, 0);
        do_req(0, 99, 0, 0);
        do_req(1, 70, 777, 2);
        chk("t4_ch2_pitch", 64'(ch_pitch[2*C +: C]), 64'd777);

        // Continuous valid for nine cycles
        burst9();

        // Reset in the middle of a pending note-on
        req_valid = 1; req_on = 1; req_key = K'(5); req_pitch = C'(999); req_wave = 2'd1;
        @(posedge clk);
        @(negedge clk);
        apply_reset();
        repeat (3) @(negedge clk);
        compare_all(0);

        // Random traffic over a small key range to exercise matches and steals
        for (int n = 0; n < 150; n++) begin
            do_req($urandom_range(0, 9) < 7, $urandom_range(0, 9),
                   $urandom_range(0, (1 << C) - 1), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
